// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART multi-channel command parser.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CH      = 3'd1,
    CMD     = 3'd2,
    PAYLOAD = 3'd3,
    CSUM    = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [1:0] CMD_PATTERN = 2'd0;
  localparam logic [1:0] CMD_FREQ    = 2'd1;
  localparam logic [1:0] CMD_START   = 2'd2;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_ACK_BYTE  = 8'h06;
  localparam logic [7:0] DEF_NAK_BYTE  = 8'h15;

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Inter-byte gap counter: clears on demand, counts while enabled and
// flags expiry when LIMIT-1 cycles have elapsed since the last clear.
module cmd_timeout_cnt #(
  parameter int LIMIT = 100000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Holds at LAST rather than wrapping, so a stalled owner still sees expiry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expire_o = en_i && (r_cnt == LAST);

endmodule

// File: rtl/uart_multi_ch_cmd_parser.sv
// Framed UART command parser producing per-channel register writes and ACK/NAK.
// Optional event counters: define UART_MULTI_CH_CMD_PARSER_STATS_EN.
module uart_multi_ch_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         DATA_BIT       = 32,
  parameter int         OUTPUT_NUM     = 16,
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE       = DEF_NAK_BYTE,
  localparam int        CH_W           = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_done_tick_i,
  input  logic                tx_busy_i,
  output logic                tx_start_o,
  output logic [7:0]          tx_data_o,
  output logic                wr_en_o,
  output logic [CH_W-1:0]     wr_ch_o,
  output logic [1:0]          wr_cmd_o,
  output logic [DATA_BIT-1:0] wr_data_o,
  output logic                timeout_tick_o
`ifdef UART_MULTI_CH_CMD_PARSER_STATS_EN
  ,
  output logic [15:0]         good_cnt_o,
  output logic [15:0]         nak_cnt_o,
  output logic [15:0]         timeout_cnt_o
`endif
);

  localparam int NB   = DATA_BIT / 8;
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_ch;
  logic [7:0]            r_cmd;
  logic [7:0]            r_csum;
  logic [DATA_BIT-1:0]   r_payload;
  logic [BC_W-1:0]       r_byte_cnt;

  logic                  r_tx_start;
  logic [7:0]            r_tx_data;
  logic                  r_wr_en;
  logic [CH_W-1:0]       r_wr_ch;
  logic [1:0]            r_wr_cmd;
  logic [DATA_BIT-1:0]   r_wr_data;
  logic                  r_timeout;

  logic w_in_pkt;
  logic w_expire;
  logic w_last_byte;
  logic w_ch_ok;
  logic w_cmd_ok;
  logic w_csum_ok;
  logic w_pkt_good;
  logic w_wr_en_next;
  logic w_tx_start_next;
  logic w_timeout_next;

  assign w_in_pkt    = (r_state == CH) || (r_state == CMD) ||
                       (r_state == PAYLOAD) || (r_state == CSUM);
  assign w_last_byte = (r_byte_cnt == BC_W'(NB - 1));
  assign w_ch_ok     = ({1'b0, r_ch} < 9'(OUTPUT_NUM));
  assign w_cmd_ok    = (r_cmd <= {6'd0, CMD_START});
  assign w_csum_ok   = (r_csum == rx_data_i);
  assign w_pkt_good  = w_ch_ok && w_cmd_ok && w_csum_ok;

  cmd_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (rx_done_tick_i || !w_in_pkt),
    .en_i     (w_in_pkt),
    .expire_o (w_expire)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (rx_done_tick_i && (rx_data_i == SYNC_BYTE)) w_state_next = CH;
      CH:      if (rx_done_tick_i) w_state_next = CMD;
      CMD:     if (rx_done_tick_i) w_state_next = PAYLOAD;
      PAYLOAD: if (rx_done_tick_i && w_last_byte) w_state_next = CSUM;
      CSUM:    if (rx_done_tick_i) w_state_next = RESP;
      RESP:    if (!tx_busy_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    // A byte landing in the expiry cycle takes priority over the abort.
    if (w_in_pkt && !rx_done_tick_i && w_expire) begin
      w_state_next = IDLE;
    end
  end

  always_comb begin
    w_wr_en_next    = 1'b0;
    w_tx_start_next = 1'b0;
    w_timeout_next  = 1'b0;
    if ((r_state == CSUM) && rx_done_tick_i) begin
      w_wr_en_next = w_pkt_good;
    end
    if ((r_state == RESP) && !tx_busy_i) begin
      w_tx_start_next = 1'b1;
    end
    if (w_in_pkt && !rx_done_tick_i && w_expire) begin
      w_timeout_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ch       <= '0;
      r_cmd      <= '0;
      r_csum     <= '0;
      r_payload  <= '0;
      r_byte_cnt <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_ch    <= '0;
      r_wr_cmd   <= '0;
      r_wr_data  <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wr_en    <= w_wr_en_next;
      r_tx_start <= w_tx_start_next;
      r_timeout  <= w_timeout_next;
      if (rx_done_tick_i) begin
        unique case (r_state)
          CH: begin
            r_ch   <= rx_data_i;
            r_csum <= rx_data_i;
          end
          CMD: begin
            r_cmd      <= rx_data_i;
            r_csum     <= r_csum ^ rx_data_i;
            r_byte_cnt <= '0;
          end
          PAYLOAD: begin
            for (int i = 0; i < NB; i++) begin
              if (r_byte_cnt == BC_W'(i)) r_payload[i*8 +: 8] <= rx_data_i;
            end
            r_csum     <= r_csum ^ rx_data_i;
            r_byte_cnt <= r_byte_cnt + BC_W'(1);
          end
          CSUM: begin
            r_tx_data <= w_pkt_good ? ACK_BYTE : NAK_BYTE;
            if (w_pkt_good) begin
              r_wr_ch   <= r_ch[CH_W-1:0];
              r_wr_cmd  <= r_cmd[1:0];
              r_wr_data <= r_payload;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign tx_start_o     = r_tx_start;
  assign tx_data_o      = r_tx_data;
  assign wr_en_o        = r_wr_en;
  assign wr_ch_o        = r_wr_ch;
  assign wr_cmd_o       = r_wr_cmd;
  assign wr_data_o      = r_wr_data;
  assign timeout_tick_o = r_timeout;

`ifdef UART_MULTI_CH_CMD_PARSER_STATS_EN
  logic        w_nak_evt;
  logic [15:0] r_good_cnt;
  logic [15:0] r_nak_cnt;
  logic [15:0] r_timeout_cnt;

  assign w_nak_evt = (r_state == CSUM) && rx_done_tick_i && !w_pkt_good;

  // Saturating event counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_good_cnt    <= '0;
      r_nak_cnt     <= '0;
      r_timeout_cnt <= '0;
    end else begin
      if (w_wr_en_next && (r_good_cnt != 16'hFFFF)) r_good_cnt <= r_good_cnt + 16'd1;
      if (w_nak_evt && (r_nak_cnt != 16'hFFFF)) r_nak_cnt <= r_nak_cnt + 16'd1;
      if (w_timeout_next && (r_timeout_cnt != 16'hFFFF)) r_timeout_cnt <= r_timeout_cnt + 16'd1;
    end
  end

  assign good_cnt_o    = r_good_cnt;
  assign nak_cnt_o     = r_nak_cnt;
  assign timeout_cnt_o = r_timeout_cnt;
`endif

endmodule

// File: tb/tb_uart_multi_ch_cmd_parser.sv
// Directed, table-driven bench for the UART multi-channel command parser.
module tb_uart_multi_ch_cmd_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_tick = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        wr_en;
  logic [3:0]  wr_ch;
  logic [1:0]  wr_cmd;
  logic [31:0] wr_data;
  logic        timeout_tick;
`ifdef UART_MULTI_CH_CMD_PARSER_STATS_EN
  logic [15:0] good_cnt, nak_cnt, timeout_cnt;
`endif

  always #5 clk = ~clk;

  uart_multi_ch_cmd_parser #(
    .DATA_BIT       (32),
    .OUTPUT_NUM     (16),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .rx_data_i      (rx_data),
    .rx_done_tick_i (rx_tick),
    .tx_busy_i      (tx_busy),
    .tx_start_o     (tx_start),
    .tx_data_o      (tx_data),
    .wr_en_o        (wr_en),
    .wr_ch_o        (wr_ch),
    .wr_cmd_o       (wr_cmd),
    .wr_data_o      (wr_data),
    .timeout_tick_o (timeout_tick)
`ifdef UART_MULTI_CH_CMD_PARSER_STATS_EN
    ,
    .good_cnt_o     (good_cnt),
    .nak_cnt_o      (nak_cnt),
    .timeout_cnt_o  (timeout_cnt)
`endif
  );

  typedef struct {
    logic [7:0]  pkt [8];
    logic        exp_wr;
    logic [3:0]  exp_ch;
    logic [1:0]  exp_cmd;
    logic [31:0] exp_data;
    logic [7:0]  exp_resp;
  } vec_t;

  vec_t vecs [7];

  int checks = 0;
  int errors = 0;

  // Event monitor, sampled on the falling edge.
  int ncyc = 0, tick_cyc = 0, wr_cyc = 0, start_cyc = 0, to_cyc = 0;
  int wr_count = 0, start_count = 0, to_count = 0;
  logic [7:0] start_data = 8'h00;

  always @(negedge clk) begin
    ncyc++;
    if (rx_tick) tick_cyc = ncyc;
    if (wr_en) begin wr_count++; wr_cyc = ncyc; end
    if (tx_start) begin start_count++; start_cyc = ncyc; start_data = tx_data; end
    if (timeout_tick) begin to_count++; to_cyc = ncyc; end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; drives one tick for exactly one cycle.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_tick = 1'b1;
    @(posedge clk); #1;
    rx_tick = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_vec(input int idx);
    int wr0, st0, to0;
    wr0 = wr_count; st0 = start_count; to0 = to_count;
    for (int i = 0; i < 8; i++) send_byte(vecs[idx].pkt[i]);
    wait_cycles(5);
    check($sformatf("v%0d_wr_cnt", idx), 64'(wr_count - wr0), 64'(vecs[idx].exp_wr));
    check($sformatf("v%0d_start_cnt", idx), 64'(start_count - st0), 64'd1);
    check($sformatf("v%0d_resp", idx), 64'(start_data), 64'(vecs[idx].exp_resp));
    check($sformatf("v%0d_wr_ch", idx), 64'(wr_ch), 64'(vecs[idx].exp_ch));
    check($sformatf("v%0d_wr_cmd", idx), 64'(wr_cmd), 64'(vecs[idx].exp_cmd));
    check($sformatf("v%0d_wr_data", idx), 64'(wr_data), 64'(vecs[idx].exp_data));
    check($sformatf("v%0d_no_timeout", idx), 64'(to_count - to0), 64'd0);
    if (vecs[idx].exp_wr) begin
      check($sformatf("v%0d_wr_lat", idx), 64'(wr_cyc - tick_cyc), 64'd1);
      check($sformatf("v%0d_start_lat", idx), 64'(start_cyc - wr_cyc), 64'd1);
    end else begin
      check($sformatf("v%0d_nak_lat", idx), 64'(start_cyc - tick_cyc), 64'd2);
    end
    $display("vec %0d: wr=%0d ch=%0h cmd=%0h data=%h resp=%h", idx,
             wr_count - wr0, wr_ch, wr_cmd, wr_data, start_data);
  endtask

  initial begin
    int wr0, st0, to0;

    vecs[0] = '{'{8'hA5, 8'h03, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0B}, 1'b1, 4'h3, 2'd0, 32'h12345678, 8'h06};
    vecs[1] = '{'{8'hA5, 8'h03, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0C}, 1'b0, 4'h3, 2'd0, 32'h12345678, 8'h15};
    vecs[2] = '{'{8'hA5, 8'h10, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h18}, 1'b0, 4'h3, 2'd0, 32'h12345678, 8'h15};
    vecs[3] = '{'{8'hA5, 8'h03, 8'h03, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08}, 1'b0, 4'h3, 2'd0, 32'h12345678, 8'h15};
    vecs[4] = '{'{8'hA5, 8'h0F, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h0E}, 1'b1, 4'hF, 2'd1, 32'hA5A5A5A5, 8'h06};
    vecs[5] = '{'{8'hA5, 8'h07, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05}, 1'b1, 4'h7, 2'd2, 32'h00000000, 8'h06};
    vecs[6] = '{'{8'hA5, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22}, 1'b1, 4'h0, 2'd0, 32'hDEADBEEF, 8'h06};

    // Reset state
    wait_cycles(3);
    check("rst_outputs", {tx_start, tx_data, wr_en, wr_ch, wr_cmd, wr_data, timeout_tick}, 64'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Junk before sync is ignored, then the table
    send_byte(8'h3C);
    for (int v = 0; v < 7; v++) run_vec(v);

    // Timeout: A5,01 then silence
    wr0 = wr_count; st0 = start_count; to0 = to_count;
    send_byte(8'hA5);
    send_byte(8'h01);
    wait_cycles(60);
    check("to_count", 64'(to_count - to0), 64'd1);
    check("to_delay_ok", 64'((to_cyc - tick_cyc >= 49) && (to_cyc - tick_cyc <= 53)), 64'd1);
    check("to_no_start", 64'(start_count - st0), 64'd0);
    check("to_no_wr", 64'(wr_count - wr0), 64'd0);
    $display("timeout: pulses=%0d delay=%0d", to_count - to0, to_cyc - tick_cyc);
    run_vec(0);

    // Byte arriving exactly in the expiry cycle keeps the packet alive
    wr0 = wr_count; st0 = start_count; to0 = to_count;
    send_byte(8'hA5);
    send_byte(8'h01);
    wait_cycles(49);
    send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h09);
    wait_cycles(5);
    check("edge_no_timeout", 64'(to_count - to0), 64'd0);
    check("edge_wr", 64'(wr_count - wr0), 64'd1);
    check("edge_wr_ch", 64'(wr_ch), 64'h1);
    check("edge_resp", 64'(start_data), 64'h06);
    $display("expiry-edge packet: wr=%0d resp=%h", wr_count - wr0, start_data);

    // tx_busy holds the response; garbage during RESP is dropped
    wr0 = wr_count; st0 = start_count; to0 = to_count;
    tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(vecs[4].pkt[i]);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    wait_cycles(17);
    check("busy_wr", 64'(wr_count - wr0), 64'd1);
    check("busy_no_start", 64'(start_count - st0), 64'd0);
    tx_busy = 1'b0;
    wait_cycles(10);
    check("busy_start_once", 64'(start_count - st0), 64'd1);
    check("busy_resp", 64'(start_data), 64'h06);
    check("busy_no_timeout", 64'(to_count - to0), 64'd0);
    $display("busy: starts=%0d resp=%h", start_count - st0, start_data);

    // Reset after the second payload byte
    st0 = start_count;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56);
    rst_n = 1'b0;
    wait_cycles(2);
    check("midrst_outputs", {tx_start, tx_data, wr_en, wr_ch, wr_cmd, wr_data, timeout_tick}, 64'd0);
    rst_n = 1'b1;
    wait_cycles(5);
    check("midrst_no_start", 64'(start_count - st0), 64'd0);
    $display("mid-packet reset: starts=%0d", start_count - st0);
    wr0 = wr_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h46);
    wait_cycles(5);
    check("post_rst_wr", 64'(wr_count - wr0), 64'd1);
    check("post_rst_ch", 64'(wr_ch), 64'h0);
    check("post_rst_cmd", 64'(wr_cmd), 64'h2);
    check("post_rst_data", 64'(wr_data), 64'h44332211);
    check("post_rst_resp", 64'(start_data), 64'h06);
    $display("post-reset packet: ch=%0h cmd=%0h data=%h resp=%h", wr_ch, wr_cmd, wr_data, start_data);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_multi_ch_cmd_parser.md
Name: uart_multi_ch_cmd_parser

Overview:
- Generalised successor to the fixed-length byte collector that feeds the serial-output engine.
- Parses framed UART command packets into per-channel register writes for OUTPUT_NUM serial-output channels, with a command field, a parametrised payload width, an XOR checksum and an inter-byte timeout.
- Sits between the UART rx/tx ports and the channel register file or serial-output engines, and answers each packet with an ACK or NAK byte on the UART tx.

Parameters:
- DATA_BIT, 32, payload width in bits; must be a multiple of 8, 8..64.
- OUTPUT_NUM, 16, number of addressable channels, 1..256.
- SYNC_BYTE, 8'hA5, packet start marker.
- TIMEOUT_CYCLES, 100000, maximum clk_i cycles allowed between bytes inside a packet.
- ACK_BYTE, 8'h06, response for a good packet.
- NAK_BYTE, 8'h15, response for a bad packet.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  synchronous reset, active-low.
- rx_data_i  in  8  received UART byte.
- rx_done_tick_i  in  1  one-cycle strobe; rx_data_i is valid in this cycle.
- tx_busy_i  in  1  UART tx is transmitting.
- tx_start_o  out  1  one-cycle strobe to start transmitting tx_data_o.
- tx_data_o  out  8  response byte.
- wr_en_o  out  1  one-cycle write strobe.
- wr_ch_o  out  CH_W=max(1,$clog2(OUTPUT_NUM))  target channel.
- wr_cmd_o  out  2  0 = pattern, 1 = freq, 2 = start.
- wr_data_o  out  DATA_BIT  payload.
- timeout_tick_o  out  1  one-cycle strobe when a packet is aborted by timeout.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset applied mid-packet discards the partial packet and sends no response.
- Packet format: SYNC, CH, CMD, then DATA_BIT/8 payload bytes (LSB first), then CSUM. CSUM is the XOR of CH, CMD and all payload bytes.
- IDLE: on a byte equal to SYNC_BYTE, go to CH. Any other byte is ignored.
- CH: latch the byte and go to CMD.
- CMD: latch the byte, clear the byte counter and go to PAYLOAD.
- PAYLOAD: shift each byte into position byte_cnt*8. After byte DATA_BIT/8-1, go to CSUM.
- CSUM: compute the check and go to RESP.
  - Good packet (CH < OUTPUT_NUM, CMD <= 2, checksum matches): pulse wr_en_o in the cycle after the CSUM byte's rx_done_tick. wr_ch_o, wr_cmd_o and wr_data_o hold from that cycle until the next write. tx_data_o = ACK_BYTE.
  - Any failure: no write; tx_data_o = NAK_BYTE.
- RESP: pulse tx_start_o for 1 cycle in the first cycle where tx_busy_i = 0, then return to IDLE.
  - Bytes arriving while in RESP are dropped.
  - tx_data_o is stable from entry to RESP until the next response.
- Latency: wr_en_o comes 1 cycle after the final rx_done_tick. tx_start_o comes 1 cycle after wr_en_o, or later if tx_busy_i is high.
- Timeout: the gap counter clears on every rx_done_tick and counts in the CH, CMD, PAYLOAD and CSUM states.
  - At TIMEOUT_CYCLES-1 without a byte: go to IDLE, pulse timeout_tick_o, no response, no write.
  - If rx_done_tick_i coincides with expiry, the byte wins and the counter clears.
- A SYNC_BYTE value inside the CH, CMD, payload or CSUM fields is ordinary data; there is no resynchronisation.
- Back-to-back packets are accepted immediately after RESP exits.

Optional Feature:
- Macro: UART_MULTI_CH_CMD_PARSER_STATS_EN.
- Defined: adds outputs good_cnt_o[15:0], nak_cnt_o[15:0] and timeout_cnt_o[15:0].
  - Each counter increments on the corresponding event and saturates at 16'hFFFF.
  - All three counters reset to 0.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package uart_cmd_pkg holds:
  - the state enum (IDLE, CH, CMD, PAYLOAD, CSUM, RESP);
  - command codes CMD_PATTERN = 0, CMD_FREQ = 1, CMD_START = 2;
  - default SYNC, ACK and NAK byte values.
- One sub-module, cmd_timeout_cnt: a clear/enable gap counter that outputs an expiry strobe.

Test Plan:
- Good packet A5,03,00,78,56,34,12,CSUM=0x03^0x00^0x78^0x56^0x34^0x12=0x0B -> wr_en_o pulse with wr_ch_o=3, wr_cmd_o=0, wr_data_o=32'h12345678, then tx_start_o with tx_data_o=8'h06.
- Same packet with CSUM=0x0C -> no wr_en_o; tx_data_o=8'h15.
- CH=0x10 with OUTPUT_NUM=16, correct checksum -> NAK, no write. CMD=3 -> NAK, no write.
- TIMEOUT_CYCLES=50: send A5,01 then idle 50 cycles -> timeout_tick_o pulse, no tx_start_o. Next a full good packet -> ACK.
- tx_busy_i held high 20 cycles after a good packet -> tx_start_o is delayed until busy drops and fires exactly once. Garbage bytes sent meanwhile are dropped.
- Reset asserted after the payload's 2nd byte -> all outputs 0 and no response. A subsequent good packet with CMD=2 and CH=0 writes correctly.
